// File: rtl/vm.sv
// vm: single-product coin-operated vending machine controller.
//
// Keeps a credit balance in 1000-won units, accepts 1000/5000-won coins,
// dispenses one beverage per request and returns change one coin per request.
// A cycle that carries more than one command is ignored entirely.
//
// Ports:
//   clk            system clock, rising edge
//   rstn           asynchronous active-low reset
//   beverage_take  dispense request (level, sampled every cycle)
//   change_take    change-return request (level, sampled every cycle)
//   coin_in        00 none, 01 1000 won, 10 5000 won, 11 invalid
//   beverage_out   one-cycle dispense pulse
//   change_out     one-cycle coin-return code (00 none, 01 1000, 10 5000)
//   money_account  current credit, 1000-won units
module vm #(
    parameter int PRICE      = 5,
    parameter int MAX_CREDIT = 20
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       beverage_take,
    input  logic       change_take,
    input  logic [1:0] coin_in,
    output logic       beverage_out,
    output logic [1:0] change_out,
    output logic [4:0] money_account
);

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1K   = 2'b01;
    localparam logic [1:0] COIN_5K   = 2'b10;

    localparam logic [5:0] MAX6   = 6'(MAX_CREDIT);
    localparam logic [4:0] PRICE5 = 5'(PRICE);

    logic [4:0] bal, bal_nxt;
    logic       bev_nxt;
    logic [1:0] chg_nxt;
    logic [1:0] n_cmd;
    logic [5:0] bal6;

    // Invalid coin code still counts as a command so it can void a cycle.
    assign n_cmd = {1'b0, coin_in != COIN_NONE} + {1'b0, beverage_take} + {1'b0, change_take};
    // One extra bit so the overflow test cannot wrap.
    assign bal6  = {1'b0, bal};

    always_comb begin
        bal_nxt = bal;
        bev_nxt = 1'b0;
        chg_nxt = COIN_NONE;
        if (n_cmd == 2'd1) begin
            if (coin_in == COIN_1K) begin
                if (bal6 + 6'd1 <= MAX6) bal_nxt = bal + 5'd1;
                else                     chg_nxt = COIN_1K;
            end else if (coin_in == COIN_5K) begin
                // Whole coin is rejected when it does not fit; no partial credit.
                if (bal6 + 6'd5 <= MAX6) bal_nxt = bal + 5'd5;
                else                     chg_nxt = COIN_5K;
            end else if (beverage_take) begin
                if (bal >= PRICE5) begin
                    bal_nxt = bal - PRICE5;
                    bev_nxt = 1'b1;
                end
            end else if (change_take) begin
                // Largest coin first, one coin per cycle.
                if (bal >= 5'd5) begin
                    bal_nxt = bal - 5'd5;
                    chg_nxt = COIN_5K;
                end else if (bal >= 5'd1) begin
                    bal_nxt = bal - 5'd1;
                    chg_nxt = COIN_1K;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bal          <= '0;
            beverage_out <= 1'b0;
            change_out   <= COIN_NONE;
        end else begin
            bal          <= bal_nxt;
            beverage_out <= bev_nxt;
            change_out   <= chg_nxt;
        end
    end

    assign money_account = bal;

endmodule

// File: tb/tb_vm.sv
// tb_vm: directed self-checking bench for the vending machine controller.
module tb_vm;

    logic       clk;
    logic       rstn;
    logic       beverage_take;
    logic       change_take;
    logic [1:0] coin_in;
    logic       beverage_out;
    logic [1:0] change_out;
    logic [4:0] money_account;

    int n_chk;
    int n_fail;

    vm #(.PRICE(5), .MAX_CREDIT(20)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .beverage_take (beverage_take),
        .change_take   (change_take),
        .coin_in       (coin_in),
        .beverage_out  (beverage_out),
        .change_out    (change_out),
        .money_account (money_account)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, sample 1 ns after the
    // following rising edge and compare all three outputs.
    task automatic step(input string tag, input logic [1:0] coin, input logic bt, input logic ct,
                        input int e_acct, input int e_bev, input int e_chg);
        @(negedge clk);
        coin_in       = coin;
        beverage_take = bt;
        change_take   = ct;
        @(posedge clk);
        #1;
        chk({tag, ".acct"}, int'(money_account), e_acct);
        chk({tag, ".bev"},  int'(beverage_out),  e_bev);
        chk({tag, ".chg"},  int'(change_out),    e_chg);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rstn          = 1'b0;
        coin_in       = 2'b00;
        beverage_take = 1'b0;
        change_take   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.acct", int'(money_account), 0);
        chk("rst.bev",  int'(beverage_out),  0);
        chk("rst.chg",  int'(change_out),    0);
        @(negedge clk);
        rstn = 1'b1;

        // Simultaneous commands are ignored as a whole.
        step("sim01bc", 2'b01, 1, 1, 0, 0, 0);
        step("sim01b",  2'b01, 1, 0, 0, 0, 0);
        step("sim01c",  2'b01, 0, 1, 0, 0, 0);
        step("sim10bc", 2'b10, 1, 1, 0, 0, 0);
        step("sim10b",  2'b10, 1, 0, 0, 0, 0);
        step("sim10c",  2'b10, 0, 1, 0, 0, 0);
        step("simbc",   2'b00, 1, 1, 0, 0, 0);
        step("sim11c",  2'b11, 0, 1, 0, 0, 0);
        step("inv11",   2'b11, 0, 0, 0, 0, 0);

        // Fill to maximum, then overflow by a 1000-won coin.
        step("fill1", 2'b10, 0, 0, 5,  0, 0);
        step("fill2", 2'b10, 0, 0, 10, 0, 0);
        step("fill3", 2'b10, 0, 0, 15, 0, 0);
        step("fill4", 2'b10, 0, 0, 20, 0, 0);
        step("ovf1k", 2'b01, 0, 0, 20, 0, 1);
        step("idle1", 2'b00, 0, 0, 20, 0, 0);

        // Purchases back to back, then top-up.
        step("buy1", 2'b00, 1, 0, 15, 1, 0);
        step("buy2", 2'b00, 1, 0, 10, 1, 0);
        step("add1", 2'b01, 0, 0, 11, 0, 0);
        step("add2", 2'b01, 0, 0, 12, 0, 0);
        step("add5", 2'b10, 0, 0, 17, 0, 0);
        // 17 + 5 exceeds 20: whole coin returned.
        step("ovf5k", 2'b10, 0, 0, 17, 0, 2);
        step("idle2", 2'b00, 0, 0, 17, 0, 0);
        step("buy3",  2'b00, 1, 0, 12, 1, 0);

        // Change drain with change_take held.
        step("drn1", 2'b00, 0, 1, 7, 0, 2);
        step("drn2", 2'b00, 0, 1, 2, 0, 2);
        step("drn3", 2'b00, 0, 1, 1, 0, 1);
        step("drn4", 2'b00, 0, 1, 0, 0, 1);
        step("drn5", 2'b00, 0, 1, 0, 0, 0);

        // Insufficient credit for a beverage.
        step("low1", 2'b01, 0, 0, 1, 0, 0);
        step("low2", 2'b01, 0, 0, 2, 0, 0);
        step("low3", 2'b01, 0, 0, 3, 0, 0);
        step("lowb", 2'b00, 1, 0, 3, 0, 0);

        // Build up to 17, take change to land on 12 with a pulse pending.
        step("pre1", 2'b10, 0, 0, 8,  0, 0);
        step("pre2", 2'b10, 0, 0, 13, 0, 0);
        step("pre3", 2'b01, 0, 0, 14, 0, 0);
        step("pre4", 2'b01, 0, 0, 15, 0, 0);
        step("pre5", 2'b01, 0, 0, 16, 0, 0);
        step("pre6", 2'b01, 0, 0, 17, 0, 0);
        step("pre7", 2'b00, 0, 1, 12, 0, 2);

        // Asynchronous reset between edges.
        #2;
        rstn = 1'b0;
        #1;
        chk("arst.acct", int'(money_account), 0);
        chk("arst.bev",  int'(beverage_out),  0);
        chk("arst.chg",  int'(change_out),    0);
        @(negedge clk);
        change_take = 1'b0;
        rstn = 1'b1;
        step("post1", 2'b01, 0, 0, 1, 0, 0);
        step("post2", 2'b00, 0, 0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
